// File: rtl/mac_drain_pkg.sv
// rtl/mac_drain_pkg.sv - shared types and constants for the MAC result drain
//
// Contents:
//   drain_state_e - drain FSM states (IDLE, STREAM)
//   NUM_BANKS     - number of frame banks: 2 when MAC_DRAIN_DOUBLE_BUF_EN is
//                   defined, 1 otherwise
//   idx_width()   - width of a lane index for n lanes (never below 1)
package mac_drain_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_e;

`ifdef MAC_DRAIN_DOUBLE_BUF_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_drain_bank.sv
// rtl/mac_drain_bank.sv - one frame of N lane results, parallel write, indexed read
//
// Ports:
//   clk_i   - clock, rising edge
//   we_i    - write all N lanes from wdata_i this edge
//   wdata_i - N packed results, lane i at [M_WIDTH*(i+1)-1 : M_WIDTH*i]
//   ridx_i  - lane to present on rdata_o
//   rdata_o - selected lane (zero for an index past N-1)
//
// Contents are not reset; the drain never reads a bank that has not been written.
module mac_drain_bank #(
    parameter int N       = 5,
    parameter int M_WIDTH = 36,
    parameter int IDX_W   = 3
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [N*M_WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0]     ridx_i,
    output logic [M_WIDTH-1:0]   rdata_o
);

    logic [M_WIDTH-1:0] mem_q [N];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= wdata_i[i*M_WIDTH +: M_WIDTH];
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < N; i++) begin
            if (ridx_i == IDX_W'(i)) begin
                rdata_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/mac_result_drain.sv
// rtl/mac_result_drain.sv - captures MAC array frames into banks and streams them out lane by lane
//
// Configuration macro: MAC_DRAIN_DOUBLE_BUF_EN (defined: two banks, otherwise one).
//
// Ports:
//   clk, rst_n - clock (rising edge) and asynchronous active-low reset
//   c_in       - N packed lane results from the MAC array
//   valid_in   - per-lane valid; all ones captures a frame, partial sets frame_err
//   out_data   - current lane result (zero while out_valid is low)
//   out_idx    - lane index of out_data
//   out_valid  - a stored frame is being presented
//   out_ready  - consumer accepts the presented lane
//   out_last   - presented lane is lane N-1
//   busy       - at least one bank holds an undrained frame
//   overflow   - sticky: a complete frame arrived with no free bank
//   frame_err  - sticky: valid_in was partially asserted
module mac_result_drain
    import mac_drain_pkg::*;
#(
    parameter int N       = 5,
    parameter int WIDTH   = 16,
    parameter int M_WIDTH = 2*WIDTH+N-1,
    parameter int IDX_W   = idx_width(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*M_WIDTH-1:0] c_in,
    input  logic [N-1:0]         valid_in,
    output logic [M_WIDTH-1:0]   out_data,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overflow,
    output logic                 frame_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);
    localparam logic [1:0]       FULL_CNT = 2'(NUM_BANKS);
    localparam bit               DBL      = (NUM_BANKS == 2);

    drain_state_e       state_q, state_d;
    logic [1:0]         count_q, count_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               last_q, last_d;
    logic               overflow_q, overflow_d;
    logic               frame_err_q, frame_err_d;

    logic               cap_req, cap_part, cap_ok;
    logic               xfer, last_xfer;
    logic [M_WIDTH-1:0] rd_word;
    logic [M_WIDTH-1:0] bank_rdata [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mac_drain_bank #(
            .N       (N),
            .M_WIDTH (M_WIDTH),
            .IDX_W   (IDX_W)
        ) u_bank (
            .clk_i   (clk),
            .we_i    (cap_ok && (wr_ptr_q == 1'(b))),
            .wdata_i (c_in),
            .ridx_i  (idx_q),
            .rdata_o (bank_rdata[b])
        );
    end

    always_comb begin
        rd_word = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rd_ptr_q == 1'(b)) begin
                rd_word = bank_rdata[b];
            end
        end
    end

    always_comb begin
        cap_req   = (valid_in == '1);
        cap_part  = (valid_in != '0) && !cap_req;
        xfer      = out_valid && out_ready;
        last_xfer = xfer && (idx_q == LAST_IDX);
        // A full store still accepts a frame when the final lane of the
        // oldest frame leaves on the same edge: that bank is free by then.
        cap_ok    = cap_req && ((count_q != FULL_CNT) || last_xfer);

        idx_d = idx_q;
        if (xfer) begin
            idx_d = last_xfer ? '0 : idx_q + IDX_W'(1);
        end

        count_d     = count_q + 2'(cap_ok) - 2'(last_xfer);
        // With a single bank the pointers stay at zero.
        wr_ptr_d    = wr_ptr_q ^ (cap_ok && DBL);
        rd_ptr_d    = rd_ptr_q ^ (last_xfer && DBL);
        overflow_d  = overflow_q | (cap_req && !cap_ok);
        frame_err_d = frame_err_q | cap_part;
        state_d     = (count_d != 2'd0) ? STREAM : IDLE;
        last_d      = (state_d == STREAM) && (idx_d == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= 2'd0;
            idx_q       <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            last_q      <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            last_q      <= last_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_valid = (state_q == STREAM);
    assign busy      = out_valid;
    assign out_last  = last_q;
    assign out_idx   = idx_q;
    assign out_data  = out_valid ? rd_word : '0;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mac_result_drain.sv
// tb/tb_mac_result_drain.sv - directed vector bench for mac_result_drain (either bank configuration)
module tb_mac_result_drain;

    localparam int N  = 5;
    localparam int MW = 36;
    localparam int IW = 3;

    logic              clk;
    logic              rst_n;
    logic [N*MW-1:0]   c_in;
    logic [N-1:0]      valid_in;
    logic [MW-1:0]     out_data;
    logic [IW-1:0]     out_idx;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              overflow;
    logic              frame_err;

    int n_checks = 0;
    int n_pass   = 0;

    mac_result_drain dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .c_in      (c_in),
        .valid_in  (valid_in),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] vin;
        int         base;
        logic       rdy;
        logic       ev;
        int         eidx;
        logic       elast;
        int         edata;
        logic       eovf;
        logic       eferr;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [N*MW-1:0] lanes(input int base);
        logic [N*MW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*MW +: MW] = MW'(base + i);
        return v;
    endfunction

    function automatic logic [43:0] expv(input logic v, input int idx, input logic last,
                                         input int data, input logic ovf, input logic ferr);
        return {v, IW'(idx), last, MW'(data), v, ovf, ferr};
    endfunction

    function automatic logic [43:0] obs();
        return {out_valid, out_idx, out_last, out_data, busy, overflow, frame_err};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic add(input logic [4:0] vin, input int base, input logic rdy, input logic ev,
                       input int eidx, input logic elast, input int edata,
                       input logic eovf, input logic eferr);
        vec_t r;
        r = '{vin, base, rdy, ev, eidx, elast, edata, eovf, eferr};
        tbl.push_back(r);
    endtask

    task automatic drive(input logic [4:0] vin, input int base, input logic rdy);
        valid_in  = vin;
        c_in      = lanes(base);
        out_ready = rdy;
    endtask

    // Called at a falling edge with lane 0 of the frame visible and out_ready high.
    // inj != 0 offers a new frame on the cycle lane N-1 is transferred.
    task automatic expect_frame(input int base, input int inj, input logic eovf, input logic eferr);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("frame%0d_lane%0d", base, i), obs(),
                expv(1'b1, i, i == N-1, base + i, eovf, eferr));
            if (i == N-1 && inj != 0) begin
                valid_in = '1;
                c_in     = lanes(inj);
            end else begin
                valid_in = '0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int  k;
        logic r;

        rst_n     = 1'b0;
        valid_in  = '0;
        c_in      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // vin, base, rdy | valid, idx, last, data, ovf, ferr
        add(5'h00,  0, 1,  0, 0, 0,  0, 0, 0);
        add(5'h1f,  1, 1,  0, 0, 0,  0, 0, 0);
        add(5'h00,  0, 1,  1, 0, 0,  1, 0, 0);
        add(5'h00,  0, 1,  1, 1, 0,  2, 0, 0);
        add(5'h00,  0, 1,  1, 2, 0,  3, 0, 0);
        add(5'h00,  0, 1,  1, 3, 0,  4, 0, 0);
        add(5'h00,  0, 1,  1, 4, 1,  5, 0, 0);
        add(5'h07,  0, 1,  0, 0, 0,  0, 0, 0);
        add(5'h00,  0, 1,  0, 0, 0,  0, 0, 1);
        add(5'h1f, 10, 0,  0, 0, 0,  0, 0, 1);
        add(5'h00,  0, 0,  1, 0, 0, 10, 0, 1);
        add(5'h00,  0, 0,  1, 0, 0, 10, 0, 1);
        add(5'h00,  0, 1,  1, 0, 0, 10, 0, 1);
        add(5'h00,  0, 0,  1, 1, 0, 11, 0, 1);
        add(5'h00,  0, 1,  1, 1, 0, 11, 0, 1);
        add(5'h00,  0, 1,  1, 2, 0, 12, 0, 1);
        add(5'h00,  0, 1,  1, 3, 0, 13, 0, 1);
        add(5'h00,  0, 1,  1, 4, 1, 14, 0, 1);
        add(5'h1f, 40, 1,  0, 0, 0,  0, 0, 1);
        add(5'h00,  0, 1,  1, 0, 0, 40, 0, 1);
        add(5'h00,  0, 1,  1, 1, 0, 41, 0, 1);
        add(5'h00,  0, 1,  1, 2, 0, 42, 0, 1);
        add(5'h00,  0, 1,  1, 3, 0, 43, 0, 1);
        add(5'h1f, 50, 1,  1, 4, 1, 44, 0, 1);
        add(5'h00,  0, 1,  1, 0, 0, 50, 0, 1);
        add(5'h00,  0, 1,  1, 1, 0, 51, 0, 1);
        add(5'h00,  0, 1,  1, 2, 0, 52, 0, 1);
        add(5'h00,  0, 1,  1, 3, 0, 53, 0, 1);
        add(5'h00,  0, 1,  1, 4, 1, 54, 0, 1);
        add(5'h00,  0, 1,  0, 0, 0,  0, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            chk($sformatf("row%0d", i), obs(),
                expv(tbl[i].ev, tbl[i].eidx, tbl[i].elast, tbl[i].edata, tbl[i].eovf, tbl[i].eferr));
            drive(tbl[i].vin, tbl[i].base, tbl[i].rdy);
        end
        @(negedge clk);

`ifdef MAC_DRAIN_DOUBLE_BUF_EN
        drive(5'h1f, 60, 0);
        @(negedge clk);
        valid_in = '0;
        @(negedge clk);
        drive(5'h1f, 70, 0);
        @(negedge clk);
        valid_in = '0;
        repeat (20) @(negedge clk);
        chk("two_stalled", obs(), expv(1, 0, 0, 60, 0, 1));
        out_ready = 1'b1;
        expect_frame(60, 80, 0, 1);
        expect_frame(70, 0, 0, 1);
        expect_frame(80, 0, 0, 1);
        chk("after_15_words", obs(), expv(0, 0, 0, 0, 0, 1));

        drive(5'h1f, 90, 0);
        @(negedge clk);
        drive(5'h1f, 100, 0);
        @(negedge clk);
        drive(5'h1f, 110, 0);
        @(negedge clk);
        valid_in = '0;
        chk("third_dropped", obs(), expv(1, 0, 0, 90, 1, 1));
        out_ready = 1'b1;
        expect_frame(90, 0, 1, 1);
        expect_frame(100, 0, 1, 1);
        chk("ovf_sticky", obs(), expv(0, 0, 0, 0, 1, 1));
`else
        drive(5'h1f, 20, 0);
        @(negedge clk);
        drive(5'h1f, 30, 0);
        @(negedge clk);
        valid_in = '0;
        chk("second_dropped", obs(), expv(1, 0, 0, 20, 1, 1));
        out_ready = 1'b1;
        expect_frame(20, 0, 1, 1);
        chk("ovf_sticky", obs(), expv(0, 0, 0, 0, 1, 1));
`endif

        drive(5'h1f, 120, 0);
        @(negedge clk);
        valid_in = '0;
        k = 0;
        for (int t = 0; t < 100 && k < N; t++) begin
            chk($sformatf("rand_%0d", t), obs(), expv(1, k, k == N-1, 120 + k, 1, 1));
            r = 1'($urandom_range(0, 1));
            out_ready = r;
            @(negedge clk);
            if (r) k++;
        end
        chk("rand_drained", 64'(k), 64'(N));
        chk("rand_idle", obs(), expv(0, 0, 0, 0, 1, 1));

        drive(5'h1f, 130, 1);
        @(negedge clk);
        valid_in = '0;
        @(negedge clk);
        chk("pre_reset", obs(), expv(1, 1, 0, 131, 1, 1));
        #2 rst_n = 1'b0;
        #1 chk("async_reset", obs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset", obs(), 64'd0);
        drive(5'h1f, 140, 1);
        @(negedge clk);
        valid_in = '0;
        expect_frame(140, 0, 0, 0);
        chk("final_idle", obs(), expv(0, 0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
